alarm_request_ctrl: RTL and testbench
=====================================

# alarm_request_ctrl

Request-side controller for the buzzer alarm interface. Collects one-cycle error events from the vending-machine control logic, latches them as pending, and drives the level-sensitive `start_alarm` request toward the buzzer driver as a coded beep pattern: 1, 2 or 3 beeps, one per error class. Sits between the vending FSM and the buzzer block, in the system `clk` domain, paced by a one-second tick strobe.

## Interface
- `ON_TICKS`, 5: seconds `start_alarm` is held high per beep. Must be ≥4 so the buzzer completes its 3-second burst.
- `GAP_TICKS`, 2: seconds `start_alarm` is held low between beeps and after the last beep. Must be ≥1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tick_1s` input 1: one-`clk`-cycle strobe, once per second.
- `err_event` input 3: one-cycle event pulses. Bit 0 is INSUFFICIENT_FUNDS, bit 1 is OUT_OF_STOCK, bit 2 is INVALID_SELECTION. Several bits may be set in the same cycle.
- `start_alarm` output 1: registered request level to the buzzer driver.
- `busy` output 1: high whenever state ≠ IDLE.
- `alarm_code` output 2: code of the alarm in progress (1/2/3); 0 when idle.
- `drop_count` output 8: saturating count of coalesced events. Present only with `ALARM_DROP_CNT_EN`.

## Operation
- **Pending register `pend[2:0]`:**
  - An event bit sets its `pend` bit.
  - A `pend` bit clears only when its class is selected.
  - If an event and a clear hit the same bit in the same cycle, the event wins and the bit stays set.
- **Selection:** lowest index wins. Bit 0 has priority over bit 1, which has priority over bit 2. Beeps = index + 1.
- **FSM states:** IDLE, HOLD, GAP.
- **IDLE:**
  - If `pend` ≠ 0 at a clock edge: select a class, clear its `pend` bit, load `beeps_left` = index + 1, load `alarm_code`, clear the tick counter, set `start_alarm` = 1, go to HOLD.
  - This does not wait for a tick.
- **HOLD:**
  - Each `tick_1s` increments the tick counter.
  - On the tick that makes the count reach `ON_TICKS`: `start_alarm` ← 0, decrement `beeps_left`, clear the counter, go to GAP.
- **GAP:**
  - Each tick increments the counter.
  - On reaching `GAP_TICKS`:
    - If `beeps_left` ≠ 0: `start_alarm` ← 1, clear the counter, go to HOLD.
    - Otherwise: `alarm_code` ← 0, go to IDLE.
- **Arithmetic:** tick counter width is clog2(max(`ON_TICKS`, `GAP_TICKS`)+1). `beeps_left` is 2 bits. No wrap is possible.
- **Events during an alarm:** they only set `pend`. The alarm in progress is never pre-empted or extended.
- **Reset** (async, any time, including mid-beep):
  - `pend` = 0, state = IDLE, counters = 0.
  - `start_alarm` = 0, `busy` = 0, `alarm_code` = 0, `drop_count` = 0.
  - The buzzer driver sees `start_alarm` fall and silences itself.

## Timing
- **Request latency:** event pulse at edge N sets `pend` at N. With the FSM in IDLE, `start_alarm` rises at edge N+1, independent of `tick_1s`.
- **Hold time:** `start_alarm` stays high for the first `ON_TICKS` ticks after assertion, counting from the first tick strictly after the rising edge.
- **Code-k alarm length:** occupies k·(`ON_TICKS`+`GAP_TICKS`) ticks, plus up to one tick of alignment.
- **Tick in the assertion cycle:** a `tick_1s` coincident with the IDLE→HOLD edge is not counted.
- **Back-to-back alarms:** the next pending class starts on the edge after GAP→IDLE. There is at least `GAP_TICKS` seconds of low request between alarms.
- **Timing-free outputs:** `busy` and `alarm_code` are registered and change on the same edges as state.

## Configuration
- **`ALARM_DROP_CNT_EN` defined:**
  - `drop_count` port exists.
  - It increments, saturating at 255, once per cycle in which any `err_event` bit arrives while its `pend` bit is already set.
  - It does not increment when the event coincides with that bit's selection clear, because that event is retained.
- **`ALARM_DROP_CNT_EN` undefined:** port and counter are absent. Behaviour is otherwise identical.

## Structure
- **Shared package `vending_pkg`:**
  - State enum IDLE/HOLD/GAP.
  - Event bit indices: `EV_FUNDS`=0, `EV_STOCK`=1, `EV_INVALID`=2.
  - `ALARM_CODE_W`=2.
- **Sub-module `alarm_tick_counter`:** tick-gated counter with clear and terminal-count compare, parameterised by limit. One instance, reloaded with `ON_TICKS` or `GAP_TICKS` per state.
- Priority select and `pend` logic stay inline.

## Test plan
- **Single event:** `err_event`=3'b001 for one cycle, defaults. Expect `start_alarm` high next edge, high for 5 ticks, low for 2 ticks, `alarm_code`=1 throughout, then `busy`=0.
- **Coded beeps:** `err_event`=3'b100. Expect three high windows of 5 ticks separated by 2-tick lows, then IDLE after 21 ticks.
- **Simultaneous events:** 3'b110 in one cycle. Expect code 2 (two beeps), then code 3 (three beeps), with no overlap.
- **Reset mid-beep:** assert `rst` during the 3rd tick of HOLD. Expect `start_alarm`=0, `busy`=0, `alarm_code`=0 asynchronously. After release, no alarm occurs without a new event.
- **Coalescing:** during a code-1 alarm, pulse bit 1 three times. Expect exactly one code-2 alarm afterwards. With `ALARM_DROP_CNT_EN`, expect `drop_count`=2.
- **Tick coincidence:** `tick_1s` in the same cycle as the IDLE→HOLD edge. Expect that tick not counted and the high window still exactly 5 subsequent ticks.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending alarm request path.
// Holds the alarm FSM state enum, event bit indices and code width.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } alarm_state_t;

   localparam int EV_W         = 3;
   localparam int EV_FUNDS     = 0;
   localparam int EV_STOCK     = 1;
   localparam int EV_INVALID   = 2;
   localparam int ALARM_CODE_W = 2;

endpackage

// File: rtl/alarm_tick_counter.sv
// Tick-gated counter with synchronous clear and terminal-count compare.
// The limit is a live input so one instance serves both beep phases.
module alarm_tick_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] count;

   // Count ticks; clear has priority so a tick in the clear cycle is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 1'b1;
      end
   end

   // This tick is the one that brings the count up to the limit
   assign hit = tick && (count == limit - 1'b1);

endmodule

// File: rtl/alarm_request_ctrl.sv
// Buzzer alarm request controller: latches error events, plays coded beeps.
// Optional saturating drop counter enabled by ALARM_DROP_CNT_EN.
module alarm_request_ctrl
   import vending_pkg::*;
#(
   parameter int ON_TICKS  = 5,
   parameter int GAP_TICKS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick_1s,
   input  logic [EV_W-1:0]         err_event,
   output logic                    start_alarm,
   output logic                    busy,
   output logic [ALARM_CODE_W-1:0] alarm_code
`ifdef ALARM_DROP_CNT_EN
   ,
   output logic [7:0]              drop_count
`endif
);

   localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int CNT_W = $clog2(MAX_T + 1);
   localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_TICKS);
   localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_TICKS);

   alarm_state_t state_q, state_n;
   logic [EV_W-1:0] pend_q, pend_n;
   logic [EV_W-1:0] clr_mask;
   logic [EV_W-1:0] sel_mask;
   logic [ALARM_CODE_W-1:0] sel_code;
   logic [1:0] beeps_q, beeps_n;
   logic [ALARM_CODE_W-1:0] code_q, code_n;
   logic start_q, start_n;
   logic busy_q;
   logic cnt_clr;
   logic cnt_hit;
   logic [CNT_W-1:0] limit;

   alarm_tick_counter #(
      .W(CNT_W)
   ) u_tick_cnt (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_1s),
      .clr  (cnt_clr),
      .limit(limit),
      .hit  (cnt_hit)
   );

   // Lowest pending index wins; code doubles as beep count
   always_comb begin
      sel_mask = '0;
      sel_code = '0;
      if (pend_q[EV_FUNDS]) begin
         sel_mask[EV_FUNDS] = 1'b1;
         sel_code = 2'd1;
      end else if (pend_q[EV_STOCK]) begin
         sel_mask[EV_STOCK] = 1'b1;
         sel_code = 2'd2;
      end else if (pend_q[EV_INVALID]) begin
         sel_mask[EV_INVALID] = 1'b1;
         sel_code = 2'd3;
      end
   end

   // Next state and request level; IDLE keeps the counter cleared so a
   // tick on the start edge is never counted
   always_comb begin
      state_n  = state_q;
      beeps_n  = beeps_q;
      code_n   = code_q;
      start_n  = start_q;
      clr_mask = '0;
      cnt_clr  = 1'b0;
      limit    = ON_LIM;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (pend_q != '0) begin
               clr_mask = sel_mask;
               beeps_n  = sel_code;
               code_n   = sel_code;
               start_n  = 1'b1;
               state_n  = HOLD;
            end
         end
         HOLD: begin
            limit = ON_LIM;
            if (cnt_hit) begin
               start_n = 1'b0;
               beeps_n = beeps_q - 2'd1;
               cnt_clr = 1'b1;
               state_n = GAP;
            end
         end
         GAP: begin
            limit = GAP_LIM;
            if (cnt_hit) begin
               cnt_clr = 1'b1;
               if (beeps_q != 2'd0) begin
                  start_n = 1'b1;
                  state_n = HOLD;
               end else begin
                  code_n  = '0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // A new event outranks the clear of the same bit
   assign pend_n = (pend_q & ~clr_mask) | err_event;

   // State, pending bits and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         beeps_q <= '0;
         code_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         pend_q  <= pend_n;
         beeps_q <= beeps_n;
         code_q  <= code_n;
         start_q <= start_n;
         busy_q  <= (state_n != IDLE);
      end
   end

   assign start_alarm = start_q;
   assign busy        = busy_q;
   assign alarm_code  = code_q;

`ifdef ALARM_DROP_CNT_EN
   logic [7:0] drop_q;
   logic       drop_hit;

   assign drop_hit = |(err_event & pend_q & ~clr_mask);

   // Saturating count of events merged into an already pending bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else if (drop_hit && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_alarm_request_ctrl.sv
// Self-checking bench for alarm_request_ctrl (defaults ON=5, GAP=2).
// Build with ALARM_DROP_CNT_EN to also check drop_count.
module tb_alarm_request_ctrl;

   localparam int ON  = 5;
   localparam int GP  = 2;
   localparam int PER = ON + GP;

   logic       clk;
   logic       rst;
   logic       tick_1s;
   logic [2:0] err_event;
   logic       start_alarm;
   logic       busy;
   logic [1:0] alarm_code;
`ifdef ALARM_DROP_CNT_EN
   logic [7:0] drop_count;
`endif

   alarm_request_ctrl #(
      .ON_TICKS (ON),
      .GAP_TICKS(GP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1s    (tick_1s),
      .err_event  (err_event),
      .start_alarm(start_alarm),
      .busy       (busy),
      .alarm_code (alarm_code)
`ifdef ALARM_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: alarm expressed as ticks elapsed since its start
   logic [2:0] m_pend;
   bit         m_active;
   int         m_code;
   int         m_ticks;
   int         m_drop;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend   = '0;
      m_active = 0;
      m_code   = 0;
      m_ticks  = 0;
      m_drop   = 0;
   endtask

   task automatic model_edge(input logic [2:0] ev, input logic tk);
      logic [2:0] clr;
      int idx;
      clr = '0;
      idx = -1;
      if (!m_active) begin
         for (int i = 2; i >= 0; i--) if (m_pend[i]) idx = i;
         if (idx >= 0) begin
            clr[idx] = 1'b1;
            m_active = 1;
            m_code   = idx + 1;
            m_ticks  = 0;
         end
      end else if (tk) begin
         m_ticks++;
         if (m_ticks == m_code * PER) begin
            m_active = 0;
            m_code   = 0;
         end
      end
      if (|(ev & m_pend & ~clr) && m_drop < 255) m_drop++;
      m_pend = (m_pend & ~clr) | ev;
   endtask

   function automatic logic model_start();
      return m_active && ((m_ticks % PER) < ON);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_start"}, {7'd0, start_alarm}, {7'd0, model_start()});
      chk({tag, "_busy"}, {7'd0, busy}, {7'd0, m_active});
      chk({tag, "_code"}, {6'd0, alarm_code}, 8'(m_code));
`ifdef ALARM_DROP_CNT_EN
      chk({tag, "_drop"}, drop_count, 8'(m_drop));
`endif
   endtask

   task automatic step(input logic [2:0] ev, input logic tk,
                       input string tag);
      err_event = ev;
      tick_1s   = tk;
      @(posedge clk);
      model_edge(ev, tk);
      #1;
      check_model(tag);
      err_event = '0;
      tick_1s   = 1'b0;
   endtask

   typedef struct {
      logic [2:0] ev;
      logic       tk;
      logic       st;
      logic       bz;
      logic [1:0] cd;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int rises;
      int busy_cnt;
      logic prev_st;
      logic [1:0] prev_cd;
      int starts[$];

      tbl[0]  = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[2]  = '{3'b000, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[3]  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[4]  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[5]  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[6]  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'd1};
      tbl[7]  = '{3'b000, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[8]  = '{3'b000, 1'b1, 1'b0, 1'b1, 2'd1};
      tbl[9]  = '{3'b000, 1'b1, 1'b0, 1'b1, 2'd1};
      tbl[10] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[11] = '{3'b000, 1'b0, 1'b0, 1'b0, 2'd0};

      rst       = 1'b1;
      tick_1s   = 1'b0;
      err_event = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_start", {7'd0, start_alarm}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_code", {6'd0, alarm_code}, 8'd0);
`ifdef ALARM_DROP_CNT_EN
      chk("rst_drop", drop_count, 8'd0);
`endif
      rst = 1'b0;

      // Single code-1 alarm, including a tick on the start edge
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ev, tbl[i].tk, "tbl");
         chk($sformatf("vec%0d_start", i), {7'd0, start_alarm},
             {7'd0, tbl[i].st});
         chk($sformatf("vec%0d_busy", i), {7'd0, busy},
             {7'd0, tbl[i].bz});
         chk($sformatf("vec%0d_code", i), {6'd0, alarm_code},
             {6'd0, tbl[i].cd});
      end

      // Code-3: three beeps, 21 ticks busy
      step(3'b100, 1'b0, "c3");
      rises    = 0;
      busy_cnt = 0;
      prev_st  = start_alarm;
      for (int i = 0; i < 30; i++) begin
         step(3'b000, 1'b1, "c3");
         if (busy) busy_cnt++;
         if (start_alarm && !prev_st) rises++;
         prev_st = start_alarm;
      end
      chk("c3_rises", 8'(rises), 8'd3);
      chk("c3_busy_len", 8'(busy_cnt), 8'd21);

      // Simultaneous events: code 2 then code 3
      starts.delete();
      prev_cd = alarm_code;
      step(3'b110, 1'b0, "sim");
      for (int i = 0; i < 60; i++) begin
         step(3'b000, 1'b1, "sim");
         if (alarm_code != 2'd0 && prev_cd == 2'd0) starts.push_back(alarm_code);
         prev_cd = alarm_code;
      end
      chk("sim_count", 8'(starts.size()), 8'd2);
      if (starts.size() == 2) begin
         chk("sim_first", 8'(starts[0]), 8'd2);
         chk("sim_second", 8'(starts[1]), 8'd3);
      end

      // Reset asserted during the third HOLD tick
      step(3'b001, 1'b0, "mid");
      step(3'b000, 1'b0, "mid");
      step(3'b000, 1'b1, "mid");
      step(3'b000, 1'b1, "mid");
      tick_1s = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("mid_start", {7'd0, start_alarm}, 8'd0);
      chk("mid_busy", {7'd0, busy}, 8'd0);
      chk("mid_code", {6'd0, alarm_code}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      tick_1s = 1'b0;
      model_reset();
      rises = 0;
      for (int i = 0; i < 20; i++) begin
         step(3'b000, 1'b1, "post");
         if (start_alarm) rises++;
      end
      chk("post_quiet", 8'(rises), 8'd0);

      // Coalescing: three bit-1 pulses during a code-1 alarm
      starts.delete();
      prev_cd = alarm_code;
      step(3'b001, 1'b0, "coal");
      for (int i = 0; i < 40; i++) begin
         step((i == 2 || i == 4 || i == 6) ? 3'b010 : 3'b000, 1'b1, "coal");
         if (alarm_code != 2'd0 && prev_cd == 2'd0) starts.push_back(alarm_code);
         prev_cd = alarm_code;
      end
      chk("coal_count", 8'(starts.size()), 8'd2);
      if (starts.size() == 2) chk("coal_second", 8'(starts[1]), 8'd2);
`ifdef ALARM_DROP_CNT_EN
      chk("coal_drop", drop_count, 8'd2);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] ev;
         logic tk;
         ev = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         tk = ($urandom_range(0, 2) == 0);
         step(ev, tk, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
